// File: rtl/hess_pkg.sv
// Shared widths and packed-bus element indices for the SIFT 3x3 Hessian stages.
package hess_pkg;

  localparam int unsigned NumElem = 9;

  localparam int unsigned H11 = 0, H12 = 1, H13 = 2;
  localparam int unsigned H21 = 3, H22 = 4, H23 = 5;
  localparam int unsigned H31 = 6, H32 = 7, H33 = 8;

  // adj[k] (row-major) = h[CofA[k]]*h[CofB[k]] - h[CofC[k]]*h[CofD[k]]
  localparam int unsigned CofA [NumElem] = '{H22, H13, H12, H23, H11, H13, H21, H12, H11};
  localparam int unsigned CofB [NumElem] = '{H33, H32, H23, H31, H33, H21, H32, H31, H22};
  localparam int unsigned CofC [NumElem] = '{H23, H12, H13, H21, H13, H11, H22, H11, H12};
  localparam int unsigned CofD [NumElem] = '{H32, H33, H22, H33, H31, H23, H31, H32, H21};

  function automatic int unsigned adj_w(input int unsigned data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int unsigned det_w(input int unsigned data_w);
    return 3 * data_w + 1;
  endfunction

endpackage

// File: rtl/hess_cofactor2.sv
// Two-stage registered a*b - c*d; the stage-1 products are exported for reuse.
module hess_cofactor2 #(
  parameter int unsigned W = 9
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  input  logic signed [W-1:0] c_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [2*W-1:0] ab_o,
  output logic signed [2*W-1:0] cd_o,
  output logic signed [2*W:0]   y_o
);

  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0] ab_d, ab_q, cd_d, cd_q;
  logic signed [PW:0]   y_d, y_q;

  // Operands are widened before the multiply so nothing is context-truncated.
  always_comb begin
    ab_d = PW'(a_i) * PW'(b_i);
    cd_d = PW'(c_i) * PW'(d_i);
    y_d  = (PW + 1)'(ab_q) - (PW + 1)'(cd_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ab_q <= '0;
      cd_q <= '0;
      y_q  <= '0;
    end else if (en_i) begin
      ab_q <= ab_d;
      cd_q <= cd_d;
      y_q  <= y_d;
    end
  end

  assign ab_o = ab_q;
  assign cd_o = cd_q;
  assign y_o  = y_q;

endmodule

// File: rtl/hessian_adj_det_pipe.sv
// 3-stage 3x3 adjugate/determinant pipeline with a global stall and tag sideband.
// Optional singularity flag (osingular) is built when HESS_DETCHK_EN is defined.
module hessian_adj_det_pipe
  import hess_pkg::*;
#(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned TAG_W   = 20,
  parameter int          DET_MIN = 1,
  localparam int unsigned ADJ_W  = adj_w(DATA_W),
  localparam int unsigned DET_W  = det_w(DATA_W)
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     ivalid,
  output logic                     oready,
  input  logic [9*DATA_W-1:0]      iH,
  input  logic [TAG_W-1:0]         itag,
  output logic                     ovalid,
  input  logic                     iready,
  output logic [9*ADJ_W-1:0]       oadj,
  output logic signed [DET_W-1:0]  odet,
  output logic [TAG_W-1:0]         otag
`ifdef HESS_DETCHK_EN
  ,
  output logic                     osingular
`endif
);

  logic en;
  assign en     = ~ovalid | iready;
  assign oready = en;

  logic signed [DATA_W-1:0]   h   [NumElem];
  logic signed [2*DATA_W-1:0] ab  [NumElem];
  logic signed [2*DATA_W-1:0] cd  [NumElem];
  logic signed [ADJ_W-1:0]    cof [NumElem];

  for (genvar k = 0; k < NumElem; k++) begin : g_cof
    assign h[k] = iH[k*DATA_W +: DATA_W];

    hess_cofactor2 #(
      .W (DATA_W)
    ) u_cof (
      .clk_i  (iclk),
      .rst_ni (irst_n),
      .en_i   (en),
      .a_i    (h[CofA[k]]),
      .b_i    (h[CofB[k]]),
      .c_i    (h[CofC[k]]),
      .d_i    (h[CofD[k]]),
      .ab_o   (ab[k]),
      .cd_o   (cd[k]),
      .y_o    (cof[k])
    );
  end

  // Only the adj11/adj21/adj31 pair products feed the determinant.
  logic unused_prod;
  assign unused_prod = ^{ab[1], ab[2], ab[4], ab[5], ab[7], ab[8],
                         cd[1], cd[2], cd[4], cd[5], cd[7], cd[8]};

  logic [2:0]               vld_q;
  logic signed [DATA_W-1:0] s1_h11_q, s1_h12_q, s1_h13_q;
  logic [TAG_W-1:0]         s1_tag_q, s2_tag_q, tag_q;
  logic signed [DET_W-1:0]  p_d, n_d, s2_p_q, s2_n_q, det_d, det_q;
  logic [9*ADJ_W-1:0]       adj_d, adj_q;

  // Row-1 expansion: P/N pair each pair product with its third element.
  always_comb begin
    p_d = DET_W'(s1_h11_q) * DET_W'(ab[0]) + DET_W'(s1_h13_q) * DET_W'(ab[6])
        + DET_W'(s1_h12_q) * DET_W'(ab[3]);
    n_d = DET_W'(s1_h13_q) * DET_W'(cd[6]) + DET_W'(s1_h11_q) * DET_W'(cd[0])
        + DET_W'(s1_h12_q) * DET_W'(cd[3]);
    det_d = s2_p_q - s2_n_q;
    adj_d = '0;
    for (int k = 0; k < NumElem; k++) begin
      adj_d[k*ADJ_W +: ADJ_W] = cof[k];
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      vld_q    <= '0;
      s1_h11_q <= '0;
      s1_h12_q <= '0;
      s1_h13_q <= '0;
      s1_tag_q <= '0;
      s2_tag_q <= '0;
      tag_q    <= '0;
      s2_p_q   <= '0;
      s2_n_q   <= '0;
      det_q    <= '0;
      adj_q    <= '0;
    end else if (en) begin
      vld_q    <= {vld_q[1:0], ivalid};
      s1_h11_q <= h[H11];
      s1_h12_q <= h[H12];
      s1_h13_q <= h[H13];
      s1_tag_q <= itag;
      s2_tag_q <= s1_tag_q;
      tag_q    <= s2_tag_q;
      s2_p_q   <= p_d;
      s2_n_q   <= n_d;
      det_q    <= det_d;
      adj_q    <= adj_d;
    end
  end

  assign ovalid = vld_q[2];
  assign oadj   = adj_q;
  assign odet   = det_q;
  assign otag   = tag_q;

`ifdef HESS_DETCHK_EN
  // One extra bit keeps |most-negative det| representable.
  localparam logic signed [DET_W:0] DetMin = (DET_W + 1)'(DET_MIN);

  logic signed [DET_W:0] det_ext, det_abs;
  logic                  sing_q;

  always_comb begin
    det_ext = (DET_W + 1)'(det_d);
    det_abs = det_ext[DET_W] ? -det_ext : det_ext;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sing_q <= 1'b0;
    end else if (en) begin
      sing_q <= (det_abs < DetMin);
    end
  end

  assign osingular = sing_q;
`else
  localparam int det_min_unused = DET_MIN;
`endif

endmodule

// File: doc/hessian_adj_det_pipe.md
# hessian_adj_det_pipe

Parametrised, flow-controlled successor to the fixed 9-bit 3×3 Hessian inverse stage. The block sits between the DoG Hessian builder and the sub-pixel offset solver in SIFT detection. Each accepted 3×3 matrix yields its full-precision adjugate and determinant after a 3-stage pipeline, plus a sideband tag that travels with it. Stages stall together under downstream backpressure, and no beat is ever dropped or duplicated.

## Interface
- DATA_W, default 9: signed width of each Hessian element.
- TAG_W, default 20: width of the pass-through sideband (keypoint x/y/scale).
- DET_MIN, default 1: singularity threshold. Used only with HESS_DETCHK_EN.
- iclk  in  1  clock.
- irst_n  in  1  reset. Asynchronous, active-low. One clock domain; polarity and synchronicity are fixed.
- ivalid  in  1  input beat valid.
- oready  out  1  input accepted when ivalid & oready.
- iH  in  9*DATA_W  signed elements, row-major: h11 in bits [DATA_W-1:0] up to h33 in the MSBs.
- itag  in  TAG_W  sideband.
- ovalid  out  1  output beat valid.
- iready  in  1  downstream ready.
- oadj  out  9*ADJ_W  adjugate, row-major, same packing as iH. ADJ_W = 2*DATA_W+1.
- odet  out  DET_W  signed determinant. DET_W = 3*DATA_W+1.
- otag  out  TAG_W  sideband aligned with oadj/odet.
- osingular  out  1  present only with HESS_DETCHK_EN.

## Operation
- Adjugate: adj_ij is the cofactor of element (j,i). Examples: adj11 = h22·h33 − h23·h32; adj12 = h13·h32 − h12·h33.
- Determinant: (h11h22h33 + h13h21h32 + h12h23h31) − (h13h22h31 + h11h23h32 + h12h21h33).
- All products and sums are signed and full-precision. No truncation or saturation occurs anywhere.
  - ADJ_W holds the difference of two DATA_W×DATA_W products.
  - DET_W holds six triple products.
  - Width is extended before every multiply so the result is not context-truncated.
- Stage 1: the 18 pairwise products are registered.
- Stage 2: the cofactors are formed, the 6 triple products are formed (pair × third element), and partial sums P and N are formed.
- Stage 3: det = P − N. The adjugate and tag are registered to the outputs.
- Each stage holds a valid bit. A single enable, en = ~ovalid | iready, advances every stage at once.
- oready = en. This is combinational from iready and the stage-3 valid bit.
- When en = 0, all data and valid registers hold.
- Bubbles do not collapse in this generation; the stall is global.

## Timing
- Latency is exactly 3 enabled cycles from acceptance to ovalid.
- Throughput is 1 beat per cycle while iready = 1.
- The outputs and otag hold stable while ovalid & ~iready.
- Reset value of every register and every output is 0: ovalid = 0, oadj = 0, odet = 0, otag = 0, osingular = 0.
- Reset asserted mid-operation discards all in-flight beats. The first beat accepted after release appears 3 cycles later.
- Data registers capture whenever en = 1, including while their valid bit is 0. The bench checks outputs only when ovalid = 1.
- With ivalid = 0 and en = 1, a bubble enters stage 1.

## Configuration
- HESS_DETCHK_EN defined:
  - Stage 3 also registers osingular = (|det| < DET_MIN).
  - The absolute value is computed at DET_W+1 bits so that the most-negative det does not overflow.
  - The downstream solver skips beats that have osingular set.
- HESS_DETCHK_EN undefined:
  - The osingular port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package hess_pkg:
  - Width functions adj_w(DATA_W) and det_w(DATA_W).
  - Element index constants H11..H33 for the packed-bus slicing used by the builder, this block and the solver.
- One sub-module, hess_cofactor2: a two-stage registered a·b − c·d with enable. It is instantiated 9 times.
- The determinant tree, the valid chain and the tag delay stay in the top-level module.

## Test plan
- DATA_W=9, iH = diag(2,2,2), tag 0x12345, iready held at 1 -> 3 cycles later oadj = diag(4,4,4), off-diagonals 0, odet = 8, otag = 0x12345.
- iH = [[2,1,0],[1,3,1],[0,1,4]] -> oadj = [[11,−4,1],[−4,8,−2],[1,−2,5]], odet = 18.
- Extremes: iH = diag(−256,−256,−256) -> adj diagonal = 65536, odet = −16777216. All-(−256) matrix -> every adj and odet = 0, and osingular = 1 with HESS_DETCHK_EN.
- Backpressure:
  - 10 back-to-back beats with a random iready pattern -> outputs arrive in order, no loss and no duplication.
  - Outputs stay stable while ~iready.
  - oready = 0 exactly when ovalid & ~iready.
- Reset: drop irst_n while 3 beats are in flight -> outputs go to 0 immediately. After release, only the newly accepted beat appears, 3 cycles after acceptance.
- HESS_DETCHK_EN with DET_MIN = 20:
  - Previous matrix (det 18) -> osingular = 1.
  - diag(3,3,3) (det 27) -> osingular = 0.
